// File: rtl/exec_md_stage.sv
// Execute stage: registers single-cycle ALU results and runs an iterative RV32M/RV64M
// multiply/divide unit, handing each result plus its sideband to the memory-stage register.
module exec_md_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CTRL_W     = 24,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_md_i,
  input  logic [2:0]        in_md_op_i,
  input  logic [XLEN-1:0]   in_a_i,
  input  logic [XLEN-1:0]   in_b_i,
  input  logic [XLEN-1:0]   in_alu_result_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [4:0]        in_rd_addr_i,
  input  logic [XLEN-1:0]   in_pcplus_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_result_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [4:0]        out_rd_addr_o,
  output logic [XLEN-1:0]   out_pcplus_o,
  output logic              busy_o
);

  localparam int unsigned     CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int unsigned     CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] XMIN    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic [XLEN-1:0]   pcplus;
  } side_t;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, rem_q;
  logic            q_neg_q, r_neg_q;
  side_t           side_q, side_in;

  logic            out_free, accept;
  logic            out_load, div_adv, out_valid_d;
  logic [XLEN-1:0] out_res_d;
  side_t           out_side_d;

  assign side_in = '{ctrl: in_ctrl_i, rd: in_rd_addr_i, pcplus: in_pcplus_i};

  // Divide pre-decode: signed ops work on magnitudes, specials bypass the iteration
  logic            in_div_sgn, in_a_neg, in_b_neg, in_div_zero, in_div_ovf;
  logic [XLEN-1:0] in_a_abs, in_b_abs, in_special;

  assign in_div_sgn  = ~in_md_op_i[0];
  assign in_a_neg    = in_div_sgn & in_a_i[XLEN-1];
  assign in_b_neg    = in_div_sgn & in_b_i[XLEN-1];
  assign in_a_abs    = in_a_neg ? XLEN'(0) - in_a_i : in_a_i;
  assign in_b_abs    = in_b_neg ? XLEN'(0) - in_b_i : in_b_i;
  assign in_div_zero = (in_b_i == {XLEN{1'b0}});
  assign in_div_ovf  = in_div_sgn && (in_a_i == XMIN) && (in_b_i == {XLEN{1'b1}});
  assign in_special  = in_div_zero ? (in_md_op_i[1] ? in_a_i : {XLEN{1'b1}})
                                   : (in_md_op_i[1] ? {XLEN{1'b0}} : XMIN);

  // Multiply: operands extended to 2*XLEN according to the op's signedness
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_a_sgn = (op_q == 2'd1) || (op_q == 2'd2);
  assign mul_b_sgn = (op_q == 2'd1);
  assign mul_a_ext = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
  assign mul_b_ext = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
  assign mul_prod  = mul_a_ext * mul_b_ext;
  assign mul_res   = (op_q == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // Restoring divide step: a_q shifts the dividend out and the quotient in
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_n, div_quo_n, div_mag, div_res;

  assign div_shift = {rem_q, a_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_rem_n = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_quo_n = {a_q[XLEN-2:0], div_ge};
  assign div_mag   = op_q[1] ? div_rem_n : div_quo_n;
  assign div_res   = (op_q[1] ? r_neg_q : q_neg_q) ? XLEN'(0) - div_mag : div_mag;

  assign out_free   = ~out_valid_o | out_ready_i;
  assign in_ready_o = (state_q == IDLE) & out_free & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign busy_o     = (state_q != IDLE);

  // Next-state and output-register load control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_load   = 1'b0;
    div_adv    = 1'b0;
    out_res_d  = in_alu_result_i;
    out_side_d = side_in;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_md_i) begin
            out_load = 1'b1;
          end else if (!in_md_op_i[2]) begin
            state_d = MUL;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
          end else if (in_div_zero || in_div_ovf) begin
            out_load  = 1'b1;
            out_res_d = in_special;
          end else begin
            state_d = DIV;
            cnt_d   = CNT_W'(XLEN - 1);
          end
        end
      end
      MUL: begin
        out_res_d  = mul_res;
        out_side_d = side_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (out_free) begin
          out_load = 1'b1;
          state_d  = IDLE;
        end
      end
      DIV: begin
        out_res_d  = div_res;
        out_side_d = side_q;
        if (cnt_q != '0) begin
          div_adv = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else if (out_free) begin
          out_load = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      out_load = 1'b0;
      div_adv  = 1'b0;
    end
    out_valid_d = flush_i ? 1'b0 : (out_load ? 1'b1 : (out_valid_o & ~out_ready_i));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and divider working registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      side_q  <= '0;
    end else if (accept && in_md_i) begin
      op_q   <= in_md_op_i[1:0];
      side_q <= side_in;
      rem_q  <= '0;
      if (in_md_op_i[2]) begin
        a_q     <= in_a_abs;
        b_q     <= in_b_abs;
        q_neg_q <= in_a_neg ^ in_b_neg;
        r_neg_q <= in_a_neg;
      end else begin
        a_q     <= in_a_i;
        b_q     <= in_b_i;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
      end
    end else if (div_adv) begin
      a_q   <= div_quo_n;
      rem_q <= div_rem_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_o   <= 1'b0;
      out_result_o  <= '0;
      out_ctrl_o    <= '0;
      out_rd_addr_o <= '0;
      out_pcplus_o  <= '0;
    end else begin
      out_valid_o <= out_valid_d;
      if (out_load) begin
        out_result_o  <= out_res_d;
        out_ctrl_o    <= out_side_d.ctrl;
        out_rd_addr_o <= out_side_d.rd;
        out_pcplus_o  <= out_side_d.pcplus;
      end
    end
  end

endmodule

// File: tb/tb_exec_md_stage.sv
// Bench for exec_md_stage: directed literal cases plus randomized traffic checked every
// cycle against a transaction-level model (result arithmetic + latency + output slot).
module tb_exec_md_stage;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CTRL_W     = 24;
  localparam int unsigned MUL_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_md = 1'b0;
  logic [2:0]        in_op = '0;
  logic [XLEN-1:0]   in_a = '0, in_b = '0, in_alu = '0, in_pc = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [4:0]        in_rd = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [XLEN-1:0]   out_result, out_pcplus;
  logic [CTRL_W-1:0] out_ctrl;
  logic [4:0]        out_rd;
  logic              busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_md_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_md_i(in_md), .in_md_op_i(in_op),
    .in_a_i(in_a), .in_b_i(in_b), .in_alu_result_i(in_alu), .in_ctrl_i(in_ctrl),
    .in_rd_addr_i(in_rd), .in_pcplus_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
    .out_ctrl_o(out_ctrl), .out_rd_addr_o(out_rd), .out_pcplus_o(out_pcplus),
    .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension result computed with plain integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int qs, rs;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) begin
          qs = $signed(a) / $signed(b);
          rs = $signed(a) % $signed(b);
          return op[1] ? rs : qs;
        end
        return op[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic int lat_of(input logic md, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    if (!md) return 1;
    if (!op[2]) return MUL_CYCLES + 1;
    if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  // Model: one pending op with a countdown, plus the output slot
  logic        m_valid, p_busy, m_free, m_load;
  logic [31:0] m_res, m_pc, p_res, p_pc, l_res, l_pc;
  logic [23:0] m_ctrl, p_ctrl, l_ctrl;
  logic [4:0]  m_rd, p_rd, l_rd;
  int          p_cyc, lat;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_valid = 0; m_res = 0; m_ctrl = 0; m_rd = 0; m_pc = 0;
      p_busy = 0; p_cyc = 0;
    end else if (flush) begin
      p_busy = 0; p_cyc = 0; m_valid = 0;
    end else begin
      m_free = !m_valid || out_ready;
      m_load = 0;
      if (p_busy) begin
        if (p_cyc > 1) p_cyc--;
        else if (m_free) begin
          m_load = 1; l_res = p_res; l_ctrl = p_ctrl; l_rd = p_rd; l_pc = p_pc;
          p_busy = 0;
        end
      end else if (in_valid && m_free) begin
        lat = lat_of(in_md, in_op, in_a, in_b);
        l_res = in_md ? ref_md(in_op, in_a, in_b) : in_alu;
        l_ctrl = in_ctrl; l_rd = in_rd; l_pc = in_pc;
        if (lat == 1) m_load = 1;
        else begin
          p_busy = 1; p_cyc = lat - 1;
          p_res = l_res; p_ctrl = l_ctrl; p_rd = l_rd; p_pc = l_pc;
        end
      end
      if (m_load) begin
        m_valid = 1; m_res = l_res; m_ctrl = l_ctrl; m_rd = l_rd; m_pc = l_pc;
      end else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, !p_busy && (!m_valid || out_ready) && !flush);
    check("busy", busy, p_busy);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_result", out_result, m_res);
      check("out_ctrl", out_ctrl, m_ctrl);
      check("out_rd", out_rd, m_rd);
      check("out_pcplus", out_pcplus, m_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic md, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] alu, input logic [4:0] rd);
    int n;
    n = 0;
    in_valid = 1; in_md = md; in_op = op; in_a = a; in_b = b; in_alu = alu; in_rd = rd;
    in_ctrl = 24'($urandom | 1); in_pc = $urandom;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready) break;
      step();
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready never rose");
    end
    step();
    in_valid = 0;
  endtask

  // Ends on the negedge where the result is visible
  task automatic wait_out(input string name, input logic [31:0] exp, input int exp_lat);
    int n;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (out_valid) break;
      step();
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: out_valid never rose", name);
    end else begin
      check(name, out_result, exp);
      check({name, "_lat"}, n, exp_lat);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran too long");
    $fatal(1, "watchdog");
  end

  initial begin
    check("ref_mulhsu", ref_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("ref_rem", ref_md(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", out_result, 0);
    check("rst_ctrl", out_ctrl, 0);
    rst_i = 1;
    step();

    send(0, 3'd0, 0, 0, 32'h0000_00AB, 5'd5);
    wait_out("alu", 32'hAB, 1);
    check("alu_rd", out_rd, 5);
    step();

    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_md = 0; in_alu = 32'h100 + i;
      @(negedge clk);
      check("b2b_ready", in_ready, 1);
      if (i > 0) check("b2b_res", out_result, 32'h100 + i - 1);
      step();
    end
    in_valid = 0;
    @(negedge clk);
    check("b2b_last", out_result, 32'h102);
    step();

    send(1, 3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    wait_out("mulh", 32'h4000_0000, 3);
    step();
    send(1, 3'd3, 32'h8000_0000, 32'h8000_0000, 0, 2);
    wait_out("mulhu", 32'h4000_0000, 3);
    step();
    send(1, 3'd0, 32'h8000_0000, 32'h8000_0000, 0, 3);
    wait_out("mul", 32'h0, 3);
    step();

    send(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 0, 4);
    wait_out("div", 32'hFFFF_FFFD, 33);
    step();
    send(1, 3'd6, 32'hFFFF_FFF9, 32'd2, 0, 4);
    wait_out("rem", 32'hFFFF_FFFF, 33);
    step();
    send(1, 3'd5, 32'd100, 32'd7, 0, 4);
    wait_out("divu", 32'd14, 33);
    step();

    send(1, 3'd4, 32'd5, 32'd0, 0, 6);
    wait_out("div0", 32'hFFFF_FFFF, 1);
    step();
    send(1, 3'd6, 32'd5, 32'd0, 0, 6);
    wait_out("rem0", 32'd5, 1);
    step();
    send(1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 7);
    wait_out("div_ovf", 32'h8000_0000, 1);
    step();
    send(1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 7);
    wait_out("rem_ovf", 32'h0, 1);
    step();

    out_ready = 0;
    send(1, 3'd5, 32'd100, 32'd7, 0, 8);
    repeat (40) step();
    @(negedge clk);
    check("bp_valid", out_valid, 1);
    check("bp_res", out_result, 14);
    check("bp_ready", in_ready, 0);
    step();
    out_ready = 1;
    @(negedge clk);
    check("bp_xfer", out_valid, 1);
    step();
    out_ready = 0;
    @(negedge clk);
    check("bp_released", out_valid, 0);
    step();
    out_ready = 1;
    send(0, 3'd0, 0, 0, 32'h55, 9);
    wait_out("bp_next", 32'h55, 1);
    step();

    send(1, 3'd4, 32'd1000, 32'd3, 0, 10);
    repeat (9) step();
    flush = 1;
    @(negedge clk);
    check("flush_block", in_ready, 0);
    step();
    flush = 0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    step();
    send(1, 3'd3, 32'd3, 32'd5, 0, 11);
    wait_out("mulhu_small", 32'h0, 3);
    step();

    send(1, 3'd0, 32'd6, 32'd7, 0, 12);
    check("mul_busy", busy, 1);
    #2 rst_i = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_result", out_result, 0);
    check("arst_ctrl", out_ctrl, 0);
    check("arst_rd", out_rd, 0);
    check("arst_pc", out_pcplus, 0);
    @(negedge clk);
    rst_i = 1;
    step();

    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_md     = ($urandom_range(0, 9) < 6);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = pick();
      in_b      = pick();
      in_alu    = $urandom;
      in_ctrl   = 24'($urandom);
      in_rd     = 5'($urandom);
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      step();
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    repeat (50) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_md_stage.md
Name: exec_md_stage

Overview:
- Parametrised execute stage: registers single-cycle ALU results and adds an iterative RV32M/RV64M multiply/divide unit.
- Sits between the decode and memory stages.
- Adds valid/ready handshaking, multi-cycle stall, flush, and configurable datapath width.
- Payload (control bundle, rd, pc+4) travels with each result into the memory-stage register.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- CTRL_W, 24, width of the opaque control bundle carried to the memory stage.
- MUL_CYCLES, 2, cycles spent in MUL state (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  kill in-flight op and output register.
- in_valid_i  in  1  decode presents an op.
- in_ready_o  out  1  stage accepts the op this cycle.
- in_md_i  in  1  1 = M-extension op, 0 = ALU pass-through.
- in_md_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a_i  in  XLEN  rs1 value.
- in_b_i  in  XLEN  rs2 value.
- in_alu_result_i  in  XLEN  precomputed ALU result.
- in_ctrl_i  in  CTRL_W  control bundle.
- in_rd_addr_i  in  5  destination register.
- in_pcplus_i  in  XLEN  pc+4.
- out_valid_o  out  1  memory-stage payload valid.
- out_ready_i  in  1  memory stage consumes the payload.
- out_result_o  out  XLEN  result.
- out_ctrl_o  out  CTRL_W  control bundle.
- out_rd_addr_o  out  5  destination register.
- out_pcplus_o  out  XLEN  pc+4.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_i=0, async):
  - FSM = IDLE; out_valid_o=0.
  - All payload outputs = 0, except out_ctrl_o, which resets to all-zero (NOP bundle).
  - Counters = 0.
- Handshakes:
  - in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i) && !flush_i.
  - Accept = in_valid_i && in_ready_o.
  - Output transfer = out_valid_o && out_ready_i.
  - Output payload holds stable while out_valid_o=1 and out_ready_i=0.
- FSM states: IDLE, MUL, DIV.
  - IDLE, accept with in_md_i=0: output register loads in_alu_result_i and sideband; out_valid_o=1 next cycle (latency 1).
  - IDLE, accept MUL* op: operands and sideband latched; cnt=MUL_CYCLES-1; go to MUL.
  - MUL: cnt decrements each cycle. At cnt==0 the result is written into the output register and FSM returns to IDLE. Latency MUL_CYCLES+1.
    - Product width is 2*XLEN. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
    - Signedness: MULH signed×signed, MULHSU signed rs1 × unsigned rs2, MULHU unsigned×unsigned.
    - Result is taken from the latched operands.
  - IDLE, accept DIV* op, special cases (resolved with latency 1, no DIV state):
    - b==0: quotient = all ones, remainder = a.
    - Signed a==MIN and b==-1: quotient = MIN, remainder = 0.
  - IDLE, accept DIV* op, otherwise: latch |a|, |b| (absolute values for signed ops) plus sign flags; cnt=XLEN-1; go to DIV.
  - DIV: one restoring-division step per cycle, MSB first. After the step at cnt==0, the output register loads the sign-corrected result and FSM returns to IDLE. Latency XLEN+1.
    - Signed quotient is negated when the operand signs differ.
    - Signed remainder takes the sign of the dividend.
- Output register writes:
  - Loads only when empty or being transferred the same cycle.
  - MUL/DIV completion while the output is full and stalled: FSM holds its final state (cnt stays 0) until the slot frees; no result is lost.
- flush_i (synchronous effect, highest priority below reset):
  - Next edge: FSM→IDLE, out_valid_o→0, counters cleared.
  - Any accept offered that cycle is blocked (in_ready_o=0).
  - Payload registers need not clear.
- busy_o = (state != IDLE).
- Arithmetic: all operations are modulo 2^XLEN. No exceptions are raised.

Test Plan:
- ALU pass-through, in_alu_result_i=0x0000_00AB, rd=5, out_ready_i=1 -> next cycle out_valid_o=1, out_result_o=0xAB, out_rd_addr_o=5; back-to-back ops accepted every cycle.
- MULH, a=0x8000_0000, b=0x8000_0000, MUL_CYCLES=2 -> in_ready_o=0 for 2 cycles; out_result_o=0x4000_0000 at latency 3; MULHU of the same operands -> 0x4000_0000, MUL -> 0.
- DIV, a=-7 (0xFFFF_FFF9), b=2 -> after 33 cycles result 0xFFFF_FFFD (-3); REM of the same operands -> 0xFFFF_FFFF (-1); DIVU, a=100, b=7 -> 14.
- Specials: DIV by b=0 with a=5 -> 0xFFFF_FFFF at latency 1; REM by b=0 -> 5; DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 and REM -> 0.
- Backpressure: out_ready_i=0 during DIV completion -> payload held, in_ready_o=0; raising out_ready_i releases exactly one transfer, then the next op is accepted.
- flush_i mid-DIV (cycle 10) -> busy_o=0 and out_valid_o=0 next cycle; a following MULHU 3×5 returns 0. Async reset asserted mid-MUL -> outputs zero immediately, without waiting for a clock edge.
